// File: rtl/bcd_digit_converter.sv
// Binary to BCD (double-dabble) or hex nibble digit converter, start/busy/done.
// Optional leading-zero blank mask: define BCD_DIGIT_CONVERTER_BLANK_EN.
module bcd_digit_converter #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  hex_mode,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  function automatic logic [35:0] f_dec_max();
    logic [35:0] m;
    m = 36'd1;
    for (int i = 0; i < DIGITS; i++) m = m * 36'd10;
    return m - 36'd1;
  endfunction

  localparam logic [35:0] DEC_MAX = f_dec_max();
  localparam logic [36:0] HEX_LIM = 37'd1 << DW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_HEX,
    S_FINISH
  } state_t;

  state_t          r_state;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_val;
  logic [DW-1:0]    r_bcd;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [DW-1:0]    r_digits;
  logic             r_ovf;

  logic [DW-1:0]    w_adj;
  logic [35:0]      w_val36;
  logic             w_nx_ovf;
  logic [DW-1:0]    w_nx_digits;

  assign w_val36 = 36'(r_val);

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i+:4] >= 4'd5) w_adj[4*i+:4] = r_bcd[4*i+:4] + 4'd3;
    end
  end

  // Result selection shared by the hex and decimal completion states.
  always_comb begin
    w_nx_ovf    = 1'b0;
    w_nx_digits = '0;
    if (r_state == S_HEX) begin
      w_nx_ovf    = {1'b0, w_val36} >= HEX_LIM;
      w_nx_digits = w_nx_ovf ? {DW{1'b1}} : DW'(r_val);
    end else begin
      w_nx_ovf    = w_val36 > DEC_MAX;
      w_nx_digits = w_nx_ovf ? {DIGITS{4'h9}} : r_bcd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_sr     <= '0;
      r_val    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_digits <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sr    <= value;
            r_val   <= value;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_state <= hex_mode ? S_HEX : S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd <= {w_adj[DW-2:0], r_sr[WIDTH-1]};
          r_sr  <= r_sr << 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FINISH;
        end
        S_HEX, S_FINISH: begin
          r_digits <= w_nx_digits;
          r_ovf    <= w_nx_ovf;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BCD_DIGIT_CONVERTER_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  function automatic logic [DIGITS-1:0] f_blank(input logic [DW-1:0] d);
    logic [DIGITS-1:0] b;
    logic              z;
    b = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z    = z & (d[4*i+:4] == 4'h0);
      b[i] = z;
    end
    return b;
  endfunction

  logic [DIGITS-1:0] r_blank;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blank <= BLANK_RST;
    end else if (r_state == S_HEX || r_state == S_FINISH) begin
      r_blank <= w_nx_ovf ? '0 : f_blank(w_nx_digits);
    end
  end

  assign blank = r_blank;
`else
  assign blank = '0;
`endif

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign digits   = r_digits;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_bcd_digit_converter.sv
// Directed self-checking bench for bcd_digit_converter (WIDTH=10 and WIDTH=13).
module tb_bcd_digit_converter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        hex_mode = 1'b0;
  logic [9:0]  value = '0;
  logic        busy, done, overflow;
  logic [11:0] digits;
  logic [2:0]  blank;

  logic        start13 = 1'b0;
  logic        hex13 = 1'b0;
  logic [12:0] value13 = '0;
  logic        busy13, done13, ovf13;
  logic [11:0] digits13;
  logic [2:0]  blank13;

  int errors = 0;
  int checks = 0;

`ifdef BCD_DIGIT_CONVERTER_BLANK_EN
  localparam logic [2:0] B_RST = 3'b110;
  localparam logic [2:0] B_0   = 3'b110;
  localparam logic [2:0] B_7   = 3'b110;
  localparam logic [2:0] B_40  = 3'b100;
`else
  localparam logic [2:0] B_RST = 3'b000;
  localparam logic [2:0] B_0   = 3'b000;
  localparam logic [2:0] B_7   = 3'b000;
  localparam logic [2:0] B_40  = 3'b000;
`endif

  bcd_digit_converter #(.WIDTH(10), .DIGITS(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .hex_mode(hex_mode),
    .value(value), .busy(busy), .done(done), .digits(digits),
    .overflow(overflow), .blank(blank)
  );

  bcd_digit_converter #(.WIDTH(13), .DIGITS(3)) u_dut13 (
    .clk(clk), .reset_n(reset_n), .start(start13), .hex_mode(hex13),
    .value(value13), .busy(busy13), .done(done13), .digits(digits13),
    .overflow(ovf13), .blank(blank13)
  );

  always #5 clk = ~clk;

  // Stimulus only: returns done latency in cycles after E0 (-1 on timeout).
  task automatic run_conv(input logic hx, input logic [9:0] v,
                          output int lat, output logic bsy0);
    lat      = -1;
    start    = 1'b1;
    hex_mode = hx;
    value    = v;
    @(posedge clk); #1;
    start = 1'b0;
    bsy0  = busy;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", overflow); end
    checks++; if (digits !== 12'h000) begin errors++; $display("FAIL rst_digits: got %h expected 000", digits); end
    checks++; if (blank !== B_RST) begin errors++; $display("FAIL rst_blank: got %b expected %b", blank, B_RST); end
    checks++; if (busy13 !== 1'b0) begin errors++; $display("FAIL rst_busy13: got %b expected 0", busy13); end
  endtask

  task automatic test_dec_999();
    int lat; logic b0;
    run_conv(1'b0, 10'd999, lat, b0);
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL d999_busy_start: got %b expected 1", b0); end
    checks++; if (lat !== 11) begin errors++; $display("FAIL d999_latency: got %0d expected 11", lat); end
    checks++; if (digits !== 12'h999) begin errors++; $display("FAIL d999_digits: got %h expected 999", digits); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL d999_ovf: got %b expected 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL d999_busy_done: got %b expected 0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL d999_done_pulse: got %b expected 0", done); end
    checks++; if (digits !== 12'h999) begin errors++; $display("FAIL d999_hold: got %h expected 999", digits); end
  endtask

  task automatic test_dec_values();
    int lat; logic b0;
    run_conv(1'b0, 10'd1000, lat, b0);
    checks++; if (digits !== 12'h999) begin errors++; $display("FAIL d1000_digits: got %h expected 999", digits); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL d1000_ovf: got %b expected 1", overflow); end
    checks++; if (blank !== 3'b000) begin errors++; $display("FAIL d1000_blank: got %b expected 000", blank); end
    run_conv(1'b0, 10'd0, lat, b0);
    checks++; if (digits !== 12'h000) begin errors++; $display("FAIL d0_digits: got %h expected 000", digits); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL d0_ovf: got %b expected 0", overflow); end
    checks++; if (blank !== B_0) begin errors++; $display("FAIL d0_blank: got %b expected %b", blank, B_0); end
    run_conv(1'b0, 10'd7, lat, b0);
    checks++; if (digits !== 12'h007) begin errors++; $display("FAIL d7_digits: got %h expected 007", digits); end
    checks++; if (blank !== B_7) begin errors++; $display("FAIL d7_blank: got %b expected %b", blank, B_7); end
    run_conv(1'b0, 10'd40, lat, b0);
    checks++; if (digits !== 12'h040) begin errors++; $display("FAIL d40_digits: got %h expected 040", digits); end
    checks++; if (blank !== B_40) begin errors++; $display("FAIL d40_blank: got %b expected %b", blank, B_40); end
    run_conv(1'b0, 10'd1023, lat, b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL d1023_ovf: got %b expected 1", overflow); end
    run_conv(1'b0, 10'd508, lat, b0);
    checks++; if (digits !== 12'h508) begin errors++; $display("FAIL d508_digits: got %h expected 508", digits); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL d508_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_hex();
    int lat; logic b0;
    run_conv(1'b1, 10'h3E7, lat, b0);
    checks++; if (lat !== 1) begin errors++; $display("FAIL hex_latency: got %0d expected 1", lat); end
    checks++; if (digits !== 12'h3E7) begin errors++; $display("FAIL hex_digits: got %h expected 3e7", digits); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL hex_ovf: got %b expected 0", overflow); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL hex_after: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_hex_overflow13();
    int lat;
    for (int t = 0; t < 2; t++) begin
      lat     = -1;
      start13 = 1'b1;
      hex13   = 1'b1;
      value13 = (t == 0) ? 13'h1000 : 13'h0FFF;
      @(posedge clk); #1;
      start13 = 1'b0;
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk); #1;
        if (done13) begin lat = k; break; end
      end
      checks++; if (lat !== 1) begin errors++; $display("FAIL hex13_latency[%0d]: got %0d expected 1", t, lat); end
      checks++; if (digits13 !== 12'hFFF) begin errors++; $display("FAIL hex13_digits[%0d]: got %h expected fff", t, digits13); end
      checks++; if (ovf13 !== (t == 0)) begin errors++; $display("FAIL hex13_ovf[%0d]: got %b expected %b", t, ovf13, t == 0); end
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic [11:0] d1;
    lat1 = -1; lat2 = -1; d1 = '0;
    start = 1'b1; hex_mode = 1'b0; value = 10'd123;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 3 || c == 5) begin
        start = 1'b1; hex_mode = 1'b1; value = 10'd999;
      end else begin
        start = 1'b0; hex_mode = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin lat1 = c; d1 = digits; break; end
    end
    start = 1'b1; hex_mode = 1'b0; value = 10'd456;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (done) begin lat2 = c; break; end
    end
    checks++; if (lat1 !== 11) begin errors++; $display("FAIL b2b_lat1: got %0d expected 11", lat1); end
    checks++; if (d1 !== 12'h123) begin errors++; $display("FAIL b2b_digits1: got %h expected 123", d1); end
    checks++; if (lat2 !== 11) begin errors++; $display("FAIL b2b_lat2: got %0d expected 11", lat2); end
    checks++; if (digits !== 12'h456) begin errors++; $display("FAIL b2b_digits2: got %h expected 456", digits); end
  endtask

  task automatic test_reset_abort();
    int lat, ndone; logic b0;
    ndone = 0;
    start = 1'b1; hex_mode = 1'b0; value = 10'd321;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (digits !== 12'h000) begin errors++; $display("FAIL abort_digits: got %h expected 000", digits); end
    checks++; if (blank !== B_RST) begin errors++; $display("FAIL abort_blank: got %b expected %b", blank, B_RST); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", ndone); end
    run_conv(1'b0, 10'd321, lat, b0);
    checks++; if (lat !== 11) begin errors++; $display("FAIL abort_restart_lat: got %0d expected 11", lat); end
    checks++; if (digits !== 12'h321) begin errors++; $display("FAIL abort_restart_digits: got %h expected 321", digits); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_dec_999();
    test_dec_values();
    test_hex();
    test_hex_overflow13();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
